// File: rtl/dp_ram_be_if.sv
// Access bus for dp_ram_be: two independent read/write ports plus status.
// Master drives requests; slave (the RAM) returns read data and status.
interface dp_ram_be_if #(
    parameter int unsigned DATA_W = 42,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LANE_W = 8
);
    localparam int unsigned NL = (DATA_W + LANE_W - 1) / LANE_W;

    logic              ena;
    logic [NL-1:0]     wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dia;
    logic [DATA_W-1:0] doa;
    logic              enb;
    logic [NL-1:0]     web;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dib;
    logic [DATA_W-1:0] dob;
    logic              init_done;
    logic              coll;

    modport master (
        output ena, wea, addra, dia, enb, web, addrb, dib,
        input  doa, dob, init_done, coll
    );

    modport slave (
        input  ena, wea, addra, dia, enb, web, addrb, dib,
        output doa, dob, init_done, coll
    );
endinterface

// File: rtl/dp_ram_be.sv
// Single-clock true dual-port RAM with byte-lane writes, selectable
// read-during-write behaviour, optional output stage and zero-fill after reset.
module dp_ram_be #(
    parameter int unsigned DATA_W     = 42,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned LANE_W     = 8,
    parameter int unsigned RD_MODE    = 0,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned INIT_CLEAR = 1
) (
    input logic        clk,
    input logic        rst_n,
    dp_ram_be_if.slave bus
);
    localparam int unsigned NL    = (DATA_W + LANE_W - 1) / LANE_W;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Expand lane enables to a per-bit mask; the top lane may be partial.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [NL-1:0] we);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int l = 0; l < NL; l++) begin
            for (int b = 0; b < LANE_W; b++) begin
                if (l * LANE_W + b < DATA_W) m[l*LANE_W+b] = we[l];
            end
        end
        return m;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              run;

    logic              a_in, b_in, a_ok, b_ok, a_wr, b_wr, same;
    logic [IDX_W-1:0]  ia, ib;
    logic [DATA_W-1:0] mask_a, mask_b, a_old, b_old, a_new, b_new, a_rd, b_rd;
    logic              a_ld, b_ld;

    logic [DATA_W-1:0] doa1_q, dob1_q;
    logic              coll_q, done_q;

    assign run = (state_q == ST_RUN);

    // Clear sequencer: walk every word once, then open for accesses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Port decode and write merge; on a shared address A's lanes override B's.
    always_comb begin
        a_in   = 32'(bus.addra) < DEPTH;
        b_in   = 32'(bus.addrb) < DEPTH;
        ia     = bus.addra[IDX_W-1:0];
        ib     = bus.addrb[IDX_W-1:0];
        a_ok   = run && rst_n && bus.ena && a_in;
        b_ok   = run && rst_n && bus.enb && b_in;
        a_wr   = a_ok && (|bus.wea);
        b_wr   = b_ok && (|bus.web);
        same   = a_ok && b_ok && (bus.addra == bus.addrb);
        mask_a = lane_mask(bus.wea);
        mask_b = lane_mask(bus.web);
        a_old  = a_in ? mem[ia] : '0;
        b_old  = b_in ? mem[ib] : '0;
        a_new  = same ? ((a_old & ~mask_b) | (bus.dib & mask_b)) : a_old;
        a_new  = (a_new & ~mask_a) | (bus.dia & mask_a);
        b_new  = same ? a_new : ((b_old & ~mask_b) | (bus.dib & mask_b));
        // A non-writing port always sees the pre-write word.
        a_rd   = (a_wr && RD_MODE == 1) ? a_new : a_old;
        b_rd   = (b_wr && RD_MODE == 1) ? b_new : b_old;
        a_ld   = run && rst_n && bus.ena && !(RD_MODE == 2 && (|bus.wea));
        b_ld   = run && rst_n && bus.enb && !(RD_MODE == 2 && (|bus.web));
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            mem[cnt_q] <= '0;
        end else begin
            if (a_wr || (same && b_wr)) mem[ia] <= a_new;
            if (b_wr && !same)          mem[ib] <= b_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doa1_q <= '0;
            dob1_q <= '0;
            coll_q <= 1'b0;
            done_q <= (INIT_CLEAR != 0) ? 1'b0 : 1'b1;
        end else begin
            if (a_ld) doa1_q <= a_rd;
            if (b_ld) dob1_q <= b_rd;
            coll_q <= same && (a_wr || b_wr);
            done_q <= (state_d == ST_RUN);
        end
    end

    // Optional second stage follows the first one cycle later.
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              lda_q, ldb_q;
            logic [DATA_W-1:0] doa2_q, dob2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lda_q  <= 1'b0;
                    ldb_q  <= 1'b0;
                    doa2_q <= '0;
                    dob2_q <= '0;
                end else begin
                    lda_q <= a_ld;
                    ldb_q <= b_ld;
                    if (lda_q) doa2_q <= doa1_q;
                    if (ldb_q) dob2_q <= dob1_q;
                end
            end

            assign bus.doa = doa2_q;
            assign bus.dob = dob2_q;
        end else begin : g_noreg
            assign bus.doa = doa1_q;
            assign bus.dob = dob1_q;
        end
    endgenerate

    assign bus.init_done = done_q;
    assign bus.coll      = coll_q;
endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: three configurations share one stimulus stream and are
// checked every cycle against an array-based reference model.
module tb_dp_ram_be;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        ena, enb;
    logic [5:0]  wea, web;
    logic [3:0]  addra, addrb;
    logic [41:0] dia, dib;

    int vectors = 0;
    int miscompares = 0;

    dp_ram_be_if #(.DATA_W(42), .ADDR_W(4), .LANE_W(8)) if0 ();
    dp_ram_be_if #(.DATA_W(42), .ADDR_W(4), .LANE_W(8)) if1 ();
    dp_ram_be_if #(.DATA_W(42), .ADDR_W(4), .LANE_W(8)) if2 ();

    assign if0.ena = ena; assign if0.wea = wea; assign if0.addra = addra; assign if0.dia = dia;
    assign if0.enb = enb; assign if0.web = web; assign if0.addrb = addrb; assign if0.dib = dib;
    assign if1.ena = ena; assign if1.wea = wea; assign if1.addra = addra; assign if1.dia = dia;
    assign if1.enb = enb; assign if1.web = web; assign if1.addrb = addrb; assign if1.dib = dib;
    assign if2.ena = ena; assign if2.wea = wea; assign if2.addra = addra; assign if2.dia = dia;
    assign if2.enb = enb; assign if2.web = web; assign if2.addrb = addrb; assign if2.dib = dib;

    dp_ram_be #(.DATA_W(42), .DEPTH(16), .ADDR_W(4), .LANE_W(8), .RD_MODE(0), .OUT_REG(0), .INIT_CLEAR(1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    dp_ram_be #(.DATA_W(42), .DEPTH(12), .ADDR_W(4), .LANE_W(8), .RD_MODE(1), .OUT_REG(1), .INIT_CLEAR(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    dp_ram_be #(.DATA_W(42), .DEPTH(16), .ADDR_W(4), .LANE_W(8), .RD_MODE(2), .OUT_REG(0), .INIT_CLEAR(1))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    // Reference model state, one slot per configuration.
    int          dep  [3] = '{16, 12, 16};
    int          mode [3] = '{0, 1, 2};
    int          oreg [3] = '{0, 1, 0};
    logic [41:0] mm   [3][16];
    int          init_left [3];
    logic [41:0] s1a [3], s1b [3], s2a [3], s2b [3];
    bit          lda [3], ldb [3], ecoll [3], edone [3];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [41:0] lmask(input logic [5:0] we);
        logic [41:0] m;
        for (int i = 0; i < 42; i++) m[i] = we[i/8];
        return m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            init_left[k] = dep[k];
            s1a[k] = '0; s1b[k] = '0; s2a[k] = '0; s2b[k] = '0;
            lda[k] = 0;  ldb[k] = 0;  ecoll[k] = 0; edone[k] = 0;
        end
    endtask

    // Predict the effect of the coming rising edge with the currently driven inputs.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic [41:0] ra, rb, olda, oldb, ma, mb;
            bit ain, bin, aw, bw, la, lb;
            ra = '0; rb = '0; la = 0; lb = 0;
            if (init_left[k] > 0) begin
                mm[k][dep[k] - init_left[k]] = '0;
                init_left[k]--;
                edone[k] = (init_left[k] == 0);
                ecoll[k] = 0;
            end else begin
                ain  = int'(addra) < dep[k];
                bin  = int'(addrb) < dep[k];
                ma   = lmask(wea);
                mb   = lmask(web);
                olda = ain ? mm[k][addra] : 42'h0;
                oldb = bin ? mm[k][addrb] : 42'h0;
                aw   = ena && ain && (wea != 0);
                bw   = enb && bin && (web != 0);
                ecoll[k] = ena && enb && ain && bin && (addra == addrb) && (aw || bw);
                if (bw) mm[k][addrb] = (mm[k][addrb] & ~mb) | (dib & mb);
                if (aw) mm[k][addra] = (mm[k][addra] & ~ma) | (dia & ma);
                ra = (aw && mode[k] == 1) ? mm[k][addra] : olda;
                rb = (bw && mode[k] == 1) ? mm[k][addrb] : oldb;
                la = ena && !(mode[k] == 2 && wea != 0);
                lb = enb && !(mode[k] == 2 && web != 0);
                edone[k] = 1;
            end
            if (lda[k]) s2a[k] = s1a[k];
            if (ldb[k]) s2b[k] = s1b[k];
            if (la) s1a[k] = ra;
            if (lb) s1b[k] = rb;
            lda[k] = la;
            ldb[k] = lb;
        end
    endtask

    task automatic chk_inst(input int k, input logic [41:0] a, input logic [41:0] b,
                            input logic c, input logic d);
        chk($sformatf("doa%0d", k), 64'(a), 64'(oreg[k] != 0 ? s2a[k] : s1a[k]));
        chk($sformatf("dob%0d", k), 64'(b), 64'(oreg[k] != 0 ? s2b[k] : s1b[k]));
        chk($sformatf("coll%0d", k), 64'(c), 64'(ecoll[k]));
        chk($sformatf("init_done%0d", k), 64'(d), 64'(edone[k]));
    endtask

    task automatic check_all();
        chk_inst(0, if0.doa, if0.dob, if0.coll, if0.init_done);
        chk_inst(1, if1.doa, if1.dob, if1.coll, if1.init_done);
        chk_inst(2, if2.doa, if2.dob, if2.coll, if2.init_done);
    endtask

    task automatic drv(input logic ea, input logic [5:0] wa, input logic [3:0] aa, input logic [41:0] da,
                       input logic eb, input logic [5:0] wb, input logic [3:0] ab, input logic [41:0] db);
        ena = ea; wea = wa; addra = aa; dia = da;
        enb = eb; web = wb; addrb = ab; dib = db;
    endtask

    task automatic drv_rand();
        logic [3:0] aa, ab;
        aa = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(8, 13));
        ab = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(8, 13));
        drv($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 6'($urandom) : 6'h0, aa,
            42'({$urandom, $urandom}),
            $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 6'($urandom) : 6'h0, ab,
            42'({$urandom, $urandom}));
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 6'h0, 4'h0, 42'h0, 0, 6'h0, 4'h0, 42'h0);
        model_reset();
        hold_reset(3);

        // Clear in progress, random traffic must be ignored; abort at count 6.
        for (int i = 0; i < 6; i++) begin drv_rand(); tick(); end
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("init_done_abort", 64'(if1.init_done), 64'h0);
        hold_reset(2);
        for (int i = 0; i < 16; i++) begin
            drv_rand();
            tick();
            chk("init_done_d12", 64'(if1.init_done), 64'(i >= 11));
            chk("init_done_d16", 64'(if0.init_done), 64'(i >= 15));
        end

        // Everything reads back as zero after the clear.
        for (int a = 0; a < 16; a++) begin
            drv(1, 6'h0, 4'(a), 42'h0, 1, 6'h0, 4'(15 - a), 42'h0);
            tick();
            chk("clear_a", 64'(if0.doa), 64'h0);
            chk("clear_b", 64'(if0.dob), 64'h0);
        end

        drv(1, 6'h3f, 4'd3, 42'h3FF_FFFF_FFFF, 0, 6'h0, 4'd0, 42'h0); tick();
        drv(0, 6'h0, 4'd0, 42'h0, 1, 6'h0, 4'd3, 42'h0);               tick();
        chk("full_wr_rd", 64'(if0.dob), 64'h3FF_FFFF_FFFF);
        drv(0, 6'h0, 4'd0, 42'h0, 0, 6'h0, 4'd0, 42'h0);               tick();
        chk("full_wr_rd_oreg", 64'(if1.dob), 64'h3FF_FFFF_FFFF);

        drv(1, 6'h03, 4'd5, 42'h2AA_AAAA_AAAA, 0, 6'h0, 4'd0, 42'h0);  tick();
        drv(0, 6'h0, 4'd0, 42'h0, 1, 6'h0, 4'd5, 42'h0);               tick();
        chk("lane_wr", 64'(if0.dob), 64'h000_0000_AAAA);

        drv(1, 6'h0, 4'd3, 42'h0, 0, 6'h0, 4'd0, 42'h0);               tick();
        drv(1, 6'h3f, 4'd7, 42'h11, 0, 6'h0, 4'd0, 42'h0);             tick();
        drv(1, 6'h3f, 4'd7, 42'h22, 0, 6'h0, 4'd0, 42'h0);             tick();
        chk("read_first", 64'(if0.doa), 64'h11);
        chk("no_change", 64'(if2.doa), 64'h3FF_FFFF_FFFF);
        drv(0, 6'h0, 4'd0, 42'h0, 0, 6'h0, 4'd0, 42'h0);               tick();
        chk("write_first", 64'(if1.doa), 64'h22);

        drv(1, 6'h01, 4'd9, 42'h0FF, 1, 6'h3f, 4'd9, 42'h3FF_FFFF_FF00); tick();
        chk("coll_ww", 64'(if0.coll), 64'h1);
        drv(0, 6'h0, 4'd0, 42'h0, 1, 6'h0, 4'd9, 42'h0);               tick();
        chk("coll_pulse", 64'(if0.coll), 64'h0);
        chk("merge_ww", 64'(if0.dob), 64'h3FF_FFFF_FFFF);
        drv(1, 6'h3f, 4'd9, 42'h55, 1, 6'h0, 4'd9, 42'h0);             tick();
        chk("coll_wr", 64'(if0.coll), 64'h1);
        chk("coll_old", 64'(if0.dob), 64'h3FF_FFFF_FFFF);

        drv(1, 6'h3f, 4'd13, 42'h123_4567_89AB, 1, 6'h3f, 4'd13, 42'h1); tick();
        chk("oor_coll", 64'(if1.coll), 64'h0);
        drv(1, 6'h0, 4'd13, 42'h0, 0, 6'h0, 4'd0, 42'h0);              tick();
        drv(0, 6'h0, 4'd0, 42'h0, 0, 6'h0, 4'd0, 42'h0);               tick();
        chk("oor_rd", 64'(if1.doa), 64'h0);

        for (int i = 0; i < 2000; i++) begin drv_rand(); tick(); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
